// File: rtl/uart_tx_frame_fsm.sv
// uart_tx_frame_fsm
//   UART transmit framer feeding Parity_Generator_Tx. A byte accepted in IDLE
//   is held on data_in_tx_par for the whole frame. The parity generator's
//   even-parity bit comes back on parity_out. The line carries start, data
//   (LSB first), optional parity and stop bits. Each bit lasts PRESCALE clocks.
//   Build option: define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_frame_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  input  logic                  parity_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] data_in_tx_par,
  input  logic                  parity_out,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  tx_q;
  logic                  busy_q;
`ifdef UART_TX_TWO_STOP_EN
  logic                  stop2_q;
`endif

  logic                  bit_end_s;
  logic [IDX_W-1:0]      idx_nxt_s;
  logic                  next_bit_s;
  logic                  par_bit_s;

  // Decode end of the current bit period and the value of the upcoming line bit
  always_comb begin
    bit_end_s  = (cnt_q == CNT_LAST);
    idx_nxt_s  = idx_q + IDX_ONE;
    next_bit_s = data_q[idx_nxt_s];
    par_bit_s  = parity_out ^ par_typ_q;
  end

  // Frame sequencer with registered line and busy outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      idx_q     <= IDX_ZERO;
      data_q    <= {DATA_WIDTH{1'b0}};
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= CNT_ZERO;
          idx_q <= IDX_ZERO;
          if (data_valid) begin
            data_q    <= data_in;
            par_en_q  <= parity_en;
            par_typ_q <= par_typ;
            state_q   <= S_START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end else begin
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end_s) begin
            cnt_q   <= CNT_ZERO;
            idx_q   <= IDX_ZERO;
            state_q <= S_DATA;
            tx_q    <= data_q[0];
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        S_DATA: begin
          if (bit_end_s) begin
            cnt_q <= CNT_ZERO;
            if (idx_q == IDX_LAST) begin
              idx_q <= IDX_ZERO;
              if (par_en_q) begin
                state_q <= S_PARITY;
                tx_q    <= par_bit_s;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              idx_q <= idx_nxt_s;
              tx_q  <= next_bit_s;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_PARITY: begin
          if (bit_end_s) begin
            cnt_q   <= CNT_ZERO;
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        S_STOP: begin
          tx_q <= 1'b1;
          if (bit_end_s) begin
            cnt_q <= CNT_ZERO;
`ifdef UART_TX_TWO_STOP_EN
            if (!stop2_q) begin
              stop2_q <= 1'b1;
            end else begin
              stop2_q <= 1'b0;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
`else
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= CNT_ZERO;
          idx_q   <= IDX_ZERO;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_in_tx_par = data_q;
  assign tx_out         = tx_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_fsm.sv
// tb_uart_tx_frame_fsm
//   Self-checking bench for uart_tx_frame_fsm (PRESCALE=4, DATA_WIDTH=8).
//   A frame-level reference model expands each accepted byte into its
//   expected line waveform. Outputs are compared to it every clock.
//   Directed frames also pin line bits and busy lengths to literal values.
//   Build option: UART_TX_TWO_STOP_EN selects two stop bits.
module tb_uart_tx_frame_fsm;

  localparam int P  = 4;
  localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP      = 2;
  localparam int BUSY_PAR   = 48;
  localparam int BUSY_NOPAR = 44;
`else
  localparam int NSTOP      = 1;
  localparam int BUSY_PAR   = 44;
  localparam int BUSY_NOPAR = 40;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] data_in = 8'h00;
  logic          data_valid = 1'b0;
  logic          parity_en = 1'b0;
  logic          par_typ = 1'b0;
  logic [DW-1:0] data_in_tx_par;
  logic          parity_out;
  logic          tx_out;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  uart_tx_frame_fsm #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .parity_en      (parity_en),
    .par_typ        (par_typ),
    .data_in_tx_par (data_in_tx_par),
    .parity_out     (parity_out),
    .tx_out         (tx_out),
    .busy           (busy)
  );

  // Stand-in for Parity_Generator_Tx: even-parity bit of the latched byte
  assign parity_out = ^data_in_tx_par;

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit            mq[$];        // expected line value, one entry per clock of the frame
  logic [DW-1:0] m_data = 8'h00;

  task automatic build_frame(input logic [DW-1:0] d, input bit pe, input bit pt);
    bit bits[$];
    bit odd_ones;
    odd_ones = (($countones(d) % 2) != 0);
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(odd_ones ^ pt);
    for (int s = 0; s < NSTOP; s++) bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int r = 0; r < P; r++) mq.push_back(bits[k]);
    end
  endtask

  // Advance the model one clock: accept when idle, otherwise consume one clock of the frame
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mq.delete();
      m_data = 8'h00;
    end else if (mq.size() == 0) begin
      if (data_valid) begin
        build_frame(data_in, parity_en, par_typ);
        m_data = data_in;
      end
    end else begin
      void'(mq.pop_front());
    end
  end

  // Compare DUT outputs to the model shortly after every rising edge
  always @(posedge CLK) begin
    #2;
    if (cmp_en) begin
      check("model_tx_out", {31'd0, tx_out}, (mq.size() != 0) ? {31'd0, mq[0]} : 32'd1);
      check("model_busy",   {31'd0, busy},   (mq.size() != 0) ? 32'd1 : 32'd0);
      check("model_data_in_tx_par", {24'd0, data_in_tx_par}, {24'd0, m_data});
    end
  end

  // ---------------- directed frame with literal expectations ----------------
  task automatic directed(input string nm, input logic [7:0] d, input logic pe, input logic pt,
                          input logic [11:0] seq, input int nb, input int blen, input bit poke);
    int c;
    @(negedge CLK);
    data_in = d; parity_en = pe; par_typ = pt; data_valid = 1'b1;
    @(negedge CLK);
    data_valid = 1'b0;
    data_in    = 8'($urandom);
    parity_en  = 1'($urandom);
    par_typ    = 1'($urandom);
    c = 0;
    while (busy === 1'b1 && c < 200) begin
      if ((c % P) == 2 && (c / P) < nb)
        check({nm, "_line_bit"}, {31'd0, tx_out}, {31'd0, seq[c / P]});
      if (poke && c == 13) begin data_valid = 1'b1; data_in = 8'hFF; end
      if (poke && c == 14) data_valid = 1'b0;
      @(negedge CLK);
      c++;
    end
    check({nm, "_busy_clocks"}, c, blen);
    check({nm, "_line_idle"}, {31'd0, tx_out}, 32'd1);
  endtask

  task automatic wait_idle(input int limit);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < limit) begin @(negedge CLK); c++; end
    check("wait_idle_bound", {31'd0, (c < limit)}, 32'd1);
  endtask

  initial begin
    int gap;
    int c;
    // Reset held low
    #1 RST = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset_tx_out", {31'd0, tx_out}, 32'd1);
    check("reset_busy",   {31'd0, busy},   32'd0);
    check("reset_data",   {24'd0, data_in_tx_par}, 32'd0);
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    check("idle_line_after_release", {31'd0, tx_out}, 32'd1);
    check("idle_busy_after_release", {31'd0, busy},   32'd0);

    // Directed frames: even parity, odd parity, no parity with ignored mid-frame request
    directed("even05", 8'h05, 1'b1, 1'b0, 12'b1100_0000_1010, 10 + NSTOP, BUSY_PAR, 1'b0);
    directed("odd07",  8'h07, 1'b1, 1'b1, 12'b1100_0000_1110, 10 + NSTOP, BUSY_PAR, 1'b0);
    directed("nopar04", 8'h04, 1'b0, 1'b0, 12'b1110_0000_1000, 9 + NSTOP, BUSY_NOPAR, 1'b1);

    // Reset abort during data bit 3 (line bit 4)
    @(negedge CLK);
    data_in = 8'h3C; parity_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
    @(negedge CLK);
    data_valid = 1'b0;
    repeat (17) @(negedge CLK);
    RST = 1'b0;
    #1;
    check("abort_tx_out", {31'd0, tx_out}, 32'd1);
    check("abort_busy",   {31'd0, busy},   32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("abort_stays_idle", {31'd0, busy}, 32'd0);
    directed("afterabortA5", 8'hA5, 1'b1, 1'b0, 12'b1101_0100_1010, 10 + NSTOP, BUSY_PAR, 1'b0);

    // Held data_valid: exactly one idle clock between back-to-back frames
    @(negedge CLK);
    data_in = 8'h05; parity_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
    @(negedge CLK);
    wait_idle(200);
    gap = 0;
    while (busy === 1'b0 && gap < 20) begin @(negedge CLK); gap++; end
    check("held_valid_gap", gap, 1);
    data_valid = 1'b0;
    wait_idle(200);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      if (RST == 1'b0) begin
        RST = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        RST = 1'b0;
      end
      data_valid = ($urandom_range(0, 5) == 0);
      data_in    = 8'($urandom);
      parity_en  = 1'($urandom);
      par_typ    = 1'($urandom);
    end
    @(negedge CLK);
    RST = 1'b1;
    data_valid = 1'b0;
    c = 0;
    while (busy !== 1'b0 && c < 200) begin @(negedge CLK); c++; end
    check("final_idle_bound", {31'd0, (c < 200)}, 32'd1);
    repeat (2) @(negedge CLK);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
